// File: rtl/divider8_seq.sv
// Signed 8-bit restoring divider producing one quotient bit per clock.
// Uses a start/busy/done handshake and flags divide-by-zero and overflow.
module divider8_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] q,
  output logic [7:0] r,
  output logic       busy,
  output logic       done,
  output logic       dz,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t     state;
  logic       sign_a;
  logic       sign_b;
  logic       dz_pend;
  logic [7:0] mag_a;   // dividend bits leave at the MSB while quotient bits enter at the LSB
  logic [7:0] mag_b;
  logic [8:0] prem;
  logic [2:0] iter;

  logic [7:0] abs_a;
  logic [7:0] abs_b;
  logic [9:0] shifted;
  logic [9:0] trial;
  logic       q_neg;
  logic [7:0] q_fix;
  logic [7:0] r_fix;
  logic [7:0] a_back;

  always_comb begin
    abs_a   = a[7] ? (~a + 8'd1) : a;
    abs_b   = b[7] ? (~b + 8'd1) : b;
    shifted = {prem, mag_a[7]};
    trial   = shifted - {2'b00, mag_b};
    q_neg   = sign_a ^ sign_b;
    q_fix   = q_neg ? (~mag_a + 8'd1) : mag_a;
    r_fix   = sign_a ? (~prem[7:0] + 8'd1) : prem[7:0];
    // mag_a still holds |a| on the divide-by-zero path, so a is rebuilt from it
    a_back  = sign_a ? (~mag_a + 8'd1) : mag_a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      dz_pend  <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      prem     <= '0;
      iter     <= '0;
      q        <= '0;
      r        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dz       <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_a  <= a[7];
            sign_b  <= b[7];
            mag_a   <= abs_a;
            mag_b   <= abs_b;
            prem    <= '0;
            iter    <= '0;
            dz_pend <= (b == 8'h00);
            busy    <= 1'b1;
            state   <= (b == 8'h00) ? FIX : CALC;
          end
        end
        CALC: begin
          prem  <= trial[9] ? shifted[8:0] : trial[8:0];
          mag_a <= {mag_a[6:0], ~trial[9]};
          iter  <= iter + 3'd1;
          if (iter == 3'd7) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (dz_pend) begin
            q        <= 8'hFF;
            r        <= a_back;
            dz       <= 1'b1;
            overflow <= 1'b0;
          end else begin
            q        <= q_fix;
            r        <= r_fix;
            dz       <= 1'b0;
            // a positive quotient magnitude of 128 only arises from -128 / -1
            overflow <= ~q_neg & mag_a[7];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider8_seq.sv
// Testbench for divider8_seq: a transaction-level arithmetic reference model
// checked every cycle, plus directed cases with literal expected values.
module tb_divider8_seq;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a     = '0;
  logic [7:0] b     = '0;
  logic [7:0] q;
  logic [7:0] r;
  logic       busy;
  logic       done;
  logic       dz;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  divider8_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .q        (q),
    .r        (r),
    .busy     (busy),
    .done     (done),
    .dz       (dz),
    .overflow (overflow)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
  } res_t;

  // Signed integer division truncates toward zero, matching the required result.
  function automatic res_t ref_div(input logic [7:0] x, input logic [7:0] y);
    res_t t;
    int   sx;
    int   sy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (sy == 0) begin
      t.q  = 8'hFF;
      t.r  = x;
      t.dz = 1'b1;
      t.ov = 1'b0;
    end else begin
      t.q  = 8'(sx / sy);
      t.r  = 8'(sx % sy);
      t.dz = 1'b0;
      t.ov = ((sx / sy) > 127);
    end
    return t;
  endfunction

  logic [7:0] exp_q    = '0;
  logic [7:0] exp_r    = '0;
  logic       exp_dz   = 1'b0;
  logic       exp_ov   = 1'b0;
  logic       exp_busy = 1'b0;
  logic       exp_done = 1'b0;
  int         cyc      = 0;
  int         fin      = 0;
  bit         pend     = 1'b0;
  res_t       pres;

  always @(posedge clk) cyc <= cyc + 1;

  // One operation at a time; results appear a fixed number of edges after acceptance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q    <= '0;
      exp_r    <= '0;
      exp_dz   <= 1'b0;
      exp_ov   <= 1'b0;
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
      pend     <= 1'b0;
    end else begin
      exp_done <= 1'b0;
      if (pend) begin
        if (cyc == fin) begin
          exp_q    <= pres.q;
          exp_r    <= pres.r;
          exp_dz   <= pres.dz;
          exp_ov   <= pres.ov;
          exp_done <= 1'b1;
          exp_busy <= 1'b0;
          pend     <= 1'b0;
        end
      end else if (start) begin
        pres     <= ref_div(a, b);
        fin      <= cyc + ((b == 8'h00) ? 1 : 9);
        pend     <= 1'b1;
        exp_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_q", q, exp_q);
    check("cyc_r", r, exp_r);
    check("cyc_dz", dz, exp_dz);
    check("cyc_ovf", overflow, exp_ov);
    check("cyc_busy", busy, exp_busy);
    check("cyc_done", done, exp_done);
    check("busy_done_excl", busy & done, 0);
  end

  // Called at a falling edge; returns at the falling edge of the done cycle.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tbv,
                       input logic [7:0] eq, input logic [7:0] er,
                       input logic edz, input logic eov, input int elat,
                       input string tag);
    int n;
    a = ta;
    b = tbv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, elat);
    check({tag, "_q"}, q, eq);
    check({tag, "_r"}, r, er);
    check({tag, "_dz"}, dz, edz);
    check({tag, "_ovf"}, overflow, eov);
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'h80;
      2: return 8'hFF;
      3: return 8'h01;
      4: return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_q", q, 0);
    check("rst_busy", busy, 0);

    do_op(8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0, 9, "p100_7");
    do_op(8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 1'b0, 9, "m100_7");
    do_op(8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 9, "p100_m7");
    do_op(8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0, 9, "m100_m7");
    do_op(8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 9, "m128_1");
    do_op(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 9, "ovf");
    do_op(8'd5, 8'h00, 8'hFF, 8'h05, 1'b1, 1'b0, 1, "dz5");
    do_op(8'h80, 8'h00, 8'hFF, 8'h80, 1'b1, 1'b0, 1, "dz_m128");

    // A start during busy is dropped; the in-flight 50/3 completes untouched.
    a = 8'd50;
    b = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'd9;
    b = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    n = 4;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("busy_start_lat", n, 9);
    check("busy_start_q", q, 8'h10);
    check("busy_start_r", r, 8'h02);
    do_op(8'd9, 8'd2, 8'h04, 8'h01, 1'b0, 1'b0, 9, "b2b");

    // Reset part-way through CALC discards the operation.
    a = 8'd100;
    b = 8'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_q", q, 0);
    check("midrst_r", r, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_dz", dz, 0);
    check("midrst_ovf", overflow, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("midrst_nodone", done, 0);
    end
    do_op(8'hFF, 8'd2, 8'h00, 8'hFF, 1'b0, 1'b0, 9, "m1_2");

    // Random traffic, including starts while busy and in the done cycle.
    repeat (20000) begin
      start = ($urandom_range(0, 2) == 0);
      a = pick();
      b = pick();
      @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
